// File: rtl/chaos_iter_scheduler.sv
// chaos_iter_scheduler
//   Sequences a chaotic-map iteration engine: triggers one iteration at a time, drops the first
//   discard_cnt results, and delivers the next sample_cnt results over a valid/ready stream.
//   A stalled sample blocks further triggering. abort ends the run cleanly. A missing engine
//   result ends the run with err_timeout set.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             run request (taken in idle only) / run termination
//   discard_cnt, sample_cnt  per-run counts, latched on start
//   eng_calcu_ctrl           one-cycle iteration trigger to the engine
//   eng_busy                 engine busy; the trigger is held off while it is set
//   eng_n1_valid, eng_*n1    engine result strobe and state
//   out_valid/ready, out_*   sample stream; out_last marks the final sample of a run
//   run_busy, done           run in progress / one-cycle end-of-run strobe
//   err_timeout, aborted     sticky status, cleared by the next accepted start
module chaos_iter_scheduler #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  discard_cnt,
  input  logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic                  eng_calcu_ctrl,
  input  logic                  eng_busy,
  input  logic                  eng_n1_valid,
  input  logic [DATA_WIDTH-1:0] eng_xn1,
  input  logic [DATA_WIDTH-1:0] eng_yn1,
  input  logic [DATA_WIDTH-1:0] eng_zn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic                  out_last,
  output logic                  run_busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  aborted
);

  localparam int unsigned TmoWidth = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoWidth:0] TmoLimit = TIMEOUT_CYCLES[TmoWidth:0];

  typedef enum logic [2:0] {StIdle, StTrig, StWait, StHold, StDrain, StFin} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  disc_q, disc_d;
  logic [CNT_WIDTH-1:0]  samp_q, samp_d;
  logic [TmoWidth-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic                  abt_q, abt_d;
  logic [CNT_WIDTH:0]    total_cnt;
  logic                  tmo_expire;

  assign total_cnt  = {1'b0, discard_cnt} + {1'b0, sample_cnt};
  assign tmo_inc    = (&tmo_q) ? tmo_q : tmo_q + TmoWidth'(1);
  // Expires in the cycle whose increment would bring the count to the limit.
  assign tmo_expire = ({1'b0, tmo_q} + (TmoWidth + 1)'(1)) >= TmoLimit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      disc_q  <= '0;
      samp_q  <= '0;
      tmo_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
      samp_q  <= samp_d;
      tmo_q   <= tmo_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      last_q  <= last_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    samp_d  = samp_q;
    tmo_d   = tmo_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    last_d  = last_q;
    err_d   = err_q;
    abt_d   = abt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          disc_d  = discard_cnt;
          samp_d  = sample_cnt;
          last_d  = 1'b0;
          err_d   = 1'b0;
          abt_d   = 1'b0;
          state_d = (total_cnt == '0) ? StFin : StTrig;
        end
      end
      StTrig: begin
        if (abort) begin
          abt_d   = 1'b1;
          state_d = StFin;
        end else if (!eng_busy) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // abort outranks a coincident result; the engine still owes one answer, so drain it.
        if (abort) begin
          tmo_d   = '0;
          state_d = StDrain;
        end else if (eng_n1_valid) begin
          if (disc_q != '0) begin
            disc_d  = disc_q - CNT_WIDTH'(1);
            // A discard-only run ends on its final discarded result.
            state_d = (disc_q == CNT_WIDTH'(1) && samp_q == '0) ? StFin : StTrig;
          end else begin
            x_d     = eng_xn1;
            y_d     = eng_yn1;
            z_d     = eng_zn1;
            last_d  = (samp_q == CNT_WIDTH'(1));
            samp_d  = (samp_q != '0) ? samp_q - CNT_WIDTH'(1) : samp_q;
            state_d = StHold;
          end
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      StHold: begin
        if (abort) begin
          abt_d   = 1'b1;
          state_d = StFin;
        end else if (out_ready) begin
          state_d = last_q ? StFin : StTrig;
        end
      end
      StDrain: begin
        if (eng_n1_valid) begin
          abt_d   = 1'b1;
          state_d = StFin;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    eng_calcu_ctrl = 1'b0;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    run_busy       = 1'b1;
    done           = 1'b0;
    unique case (state_q)
      StIdle:  run_busy = 1'b0;
      StTrig:  eng_calcu_ctrl = !eng_busy && !abort;
      StHold: begin
        out_valid = 1'b1;
        out_last  = last_q;
      end
      StFin:   done = 1'b1;
      default: ;
    endcase
  end

  assign out_x       = x_q;
  assign out_y       = y_q;
  assign out_z       = z_q;
  assign err_timeout = err_q;
  assign aborted     = abt_q;

endmodule

// File: tb/tb_chaos_iter_scheduler.sv
// Bench for chaos_iter_scheduler. A behavioural engine numbers every trigger and answers with
// precomputed random data after a programmable latency. Each run pushes the results it should
// deliver (results discard+1 .. discard+sample of that run) onto a queue; a monitor pops and
// compares on every accepted sample. A second instance with an 8-cycle timeout shares the inputs.
module tb_chaos_iter_scheduler;

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
    logic        last;
  } samp_t;

  logic        clk, rst, start, abort;
  logic [15:0] discard_cnt, sample_cnt;
  logic        eng_busy, eng_n1_valid;
  logic [63:0] eng_xn1, eng_yn1, eng_zn1;
  logic        out_ready;
  logic        eng_calcu_ctrl, out_valid, out_last, run_busy, done, err_timeout, aborted;
  logic [63:0] out_x, out_y, out_z;
  logic        ctrl_b, valid_b, last_b, busy_b, done_b, err_b, abt_b;
  logic [63:0] x_b, y_b, z_b;

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0;
  samp_t       exp_q[$];
  logic [63:0] dx[1024], dy[1024], dz[1024];
  int          eng_lat = 4;
  bit          eng_mute = 0;
  int          trig_total = 0, last_trig_cyc = 0;
  int          due_q[$], idx_q[$];
  int          done_cnt = 0, done_cyc = 0, done_b_cnt = 0, done_b_cyc = 0;
  int          acc_cnt = 0, acc_cyc = 0, valid_seen = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int          base = 0, start_cyc = 0;

  chaos_iter_scheduler #(.DATA_WIDTH(64), .CNT_WIDTH(16), .TIMEOUT_CYCLES(255)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .discard_cnt(discard_cnt), .sample_cnt(sample_cnt),
    .eng_calcu_ctrl(eng_calcu_ctrl), .eng_busy(eng_busy), .eng_n1_valid(eng_n1_valid),
    .eng_xn1(eng_xn1), .eng_yn1(eng_yn1), .eng_zn1(eng_zn1),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_last(out_last), .run_busy(run_busy), .done(done), .err_timeout(err_timeout),
    .aborted(aborted)
  );

  chaos_iter_scheduler #(.DATA_WIDTH(64), .CNT_WIDTH(16), .TIMEOUT_CYCLES(8)) u_dut_tmo (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .discard_cnt(discard_cnt), .sample_cnt(sample_cnt),
    .eng_calcu_ctrl(ctrl_b), .eng_busy(eng_busy), .eng_n1_valid(eng_n1_valid),
    .eng_xn1(eng_xn1), .eng_yn1(eng_yn1), .eng_zn1(eng_zn1),
    .out_valid(valid_b), .out_ready(out_ready), .out_x(x_b), .out_y(y_b), .out_z(z_b),
    .out_last(last_b), .run_busy(busy_b), .done(done_b), .err_timeout(err_b),
    .aborted(abt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine model: counts triggers, answers each after eng_lat cycles unless muted.
  // Pending answers survive a scheduler reset so a late result reaches an idle scheduler.
  initial begin : engine
    eng_n1_valid = 1'b0;
    eng_xn1 = '0;
    eng_yn1 = '0;
    eng_zn1 = '0;
    forever begin
      @(negedge clk);
      eng_n1_valid = 1'b0;
      if (!rst && eng_calcu_ctrl) begin
        trig_total++;
        last_trig_cyc = cyc;
        if (!eng_mute) begin
          due_q.push_back(cyc + eng_lat);
          idx_q.push_back(trig_total % 1024);
        end
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        eng_n1_valid = 1'b1;
        eng_xn1 = dx[idx_q[0]];
        eng_yn1 = dy[idx_q[0]];
        eng_zn1 = dz[idx_q[0]];
        void'(due_q.pop_front());
        void'(idx_q.pop_front());
      end
    end
  end

  initial begin : ready_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) < 6);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    samp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (done_b) begin
          done_b_cnt++;
          done_b_cyc = cyc;
        end
        if (out_valid) valid_seen++;
        if (eng_calcu_ctrl) chk("trig_while_busy", eng_busy, 0);
        if (out_valid && out_ready && !abort) begin
          acc_cnt++;
          acc_cyc = cyc;
          chk("sample_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_x", out_x, e.x);
            chk("out_y", out_y, e.y);
            chk("out_z", out_z, e.z);
            chk("out_last", out_last, e.last);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not reach its end, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check_idle(input string tag);
    chk({tag, "_flags"}, {eng_calcu_ctrl, out_valid, out_last, run_busy, done, err_timeout,
                          aborted}, 0);
    chk({tag, "_data"}, out_x | out_y | out_z, 0);
  endtask

  task automatic launch(input int d, input int s, input bit push);
    samp_t e;
    base = trig_total;
    if (push) begin
      for (int i = 0; i < s; i++) begin
        e.x = dx[(base + d + 1 + i) % 1024];
        e.y = dy[(base + d + 1 + i) % 1024];
        e.z = dz[(base + d + 1 + i) % 1024];
        e.last = (i == s - 1);
        exp_q.push_back(e);
      end
    end
    discard_cnt = 16'(d);
    sample_cnt  = 16'(s);
    start       = 1'b1;
    start_cyc   = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound, input int dn0);
    int k = 0;
    while (done_cnt == dn0 && k < bound) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt != dn0, 1);
    tick();
  endtask

  task automatic run(input int d, input int s, input int lat, input string tag);
    int dn0;
    eng_lat = lat;
    dn0 = done_cnt;
    launch(d, s, 1);
    wait_done(tag, 3000, dn0);
    chk({tag, "_trigs"}, trig_total - base, d + s);
    chk({tag, "_done_once"}, done_cnt - dn0, 1);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin : stimulus
    int dn0, db0, t0, k, a0, vs0, tr;
    logic [63:0] hx, hy, hz;
    logic hl;
    for (int i = 0; i < 1024; i++) begin
      dx[i] = {$urandom, $urandom};
      dy[i] = {$urandom, $urandom};
      dz[i] = {$urandom, $urandom};
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; eng_busy = 1'b0;
    discard_cnt = '0; sample_cnt = '0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Basic run: two discards, three samples, 10-cycle engine.
    ready_mode = 0;
    a0 = acc_cnt;
    run(2, 3, 10, "basic");
    chk("basic_accepts", acc_cnt - a0, 3);
    chk("basic_done_lat", done_cyc - acc_cyc, 1);

    // Zero counts: straight to FIN, done in the cycle after start is taken.
    dn0 = done_cnt;
    launch(0, 0, 1);
    wait_done("zero", 10, dn0);
    chk("zero_done_lat", done_cyc - start_cyc, 1);
    chk("zero_trigs", trig_total - base, 0);

    // Busy gating: engine busy for the first five TRIG cycles.
    eng_lat = 3;
    eng_busy = 1'b1;
    dn0 = done_cnt;
    launch(0, 1, 1);
    repeat (5) begin
      chk("busy_gate", eng_calcu_ctrl, 0);
      tick();
    end
    eng_busy = 1'b0;
    #1;
    chk("busy_fire", eng_calcu_ctrl, 1);
    wait_done("busy", 50, dn0);
    chk("busy_trigs", trig_total - base, 1);

    // Backpressure: first sample held for 20 cycles with no further trigger.
    eng_lat = 3;
    ready_mode = 2;
    dn0 = done_cnt;
    launch(0, 2, 1);
    t0 = base;
    k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    chk("bp_valid", out_valid, 1);
    hx = out_x; hy = out_y; hz = out_z; hl = out_last;
    tr = trig_total;
    repeat (20) begin
      tick();
      chk("bp_stable", {out_valid, out_x == hx, out_y == hy, out_z == hz, out_last == hl},
          5'h1f);
    end
    chk("bp_no_trig", trig_total, tr);
    ready_mode = 0;
    k = 0;
    while (trig_total == tr && k < 20) begin
      tick();
      k++;
    end
    chk("bp_gap", (last_trig_cyc - acc_cyc) >= 1, 1);
    wait_done("bp", 100, dn0);
    chk("bp_trigs", trig_total - t0, 2);
    chk("bp_drained", exp_q.size(), 0);

    // Randomized runs with random backpressure.
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      run($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 6), "rand");
    end
    ready_mode = 0;

    // Abort in WAIT; the result lands four cycles after abort; a start in DRAIN is ignored.
    eng_lat = 5;
    dn0 = done_cnt;
    vs0 = valid_seen;
    launch(0, 1, 0);
    t0 = base;
    k = 0;
    while (trig_total == t0 && k < 20) begin
      tick();
      k++;
    end
    chk("ab_trig", trig_total - t0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ab", 50, dn0);
    chk("ab_no_valid", valid_seen - vs0, 0);
    chk("ab_aborted", aborted, 1);
    chk("ab_trigs", trig_total - t0, 1);
    chk("ab_idle", run_busy, 0);

    // Timeout: silent engine; the 8-cycle instance expires first, then the 255-cycle one.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_mute = 1'b1;
    dn0 = done_cnt;
    db0 = done_b_cnt;
    launch(0, 1, 0);
    k = 0;
    while (done_b_cnt == db0 && k < 40) begin
      tick();
      k++;
    end
    chk("tmo8_done", done_b_cnt - db0, 1);
    chk("tmo8_latency", done_b_cyc - last_trig_cyc, 9);
    chk("tmo8_err", err_b, 1);
    chk("tmo255_still_busy", run_busy, 1);
    wait_done("tmo255", 400, dn0);
    chk("tmo255_latency", done_cyc - last_trig_cyc, 256);
    chk("tmo255_err", err_timeout, 1);
    eng_mute = 1'b0;
    dn0 = done_cnt;
    launch(0, 0, 1);
    wait_done("tmo_clear", 10, dn0);
    chk("tmo_clear_a", err_timeout, 0);
    chk("tmo_clear_b", err_b, 0);

    // Reset while a sample is held: everything clears, no done.
    eng_lat = 3;
    ready_mode = 2;
    dn0 = done_cnt;
    launch(0, 2, 1);
    k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    chk("rh_valid", out_valid, 1);
    rst = 1'b1;
    #2;
    check_idle("rh_reset");
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rh_no_done", done_cnt - dn0, 0);
    chk("rh_idle", {out_valid, run_busy}, 0);
    ready_mode = 0;

    // Reset in WAIT; the late engine result must be ignored in IDLE.
    eng_lat = 6;
    launch(0, 1, 0);
    t0 = base;
    k = 0;
    while (trig_total == t0 && k < 20) begin
      tick();
      k++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vs0 = valid_seen;
    dn0 = done_cnt;
    repeat (12) tick();
    chk("rw_no_valid", valid_seen - vs0, 0);
    chk("rw_no_done", done_cnt - dn0, 0);
    chk("rw_idle", run_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
